hdmi_island_scheduler: RTL and testbench

//   Sequences HDMI data-island periods inside horizontal blanking and arbitrates

---
 rtl/hdmi_island_scheduler.sv | 175 +++++++++++++++++
 tb/tb_hdmi_island_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_island_scheduler.sv
// hdmi_island_scheduler
//   Sequences HDMI data-island periods inside horizontal blanking and arbitrates
//   four packet sources (ACR, audio sample, AVI infoframe, audio infoframe) onto
//   the shared TERC4 packet encoder.  Island shape:
//     preamble (PREAMBLE) -> leading guard (GUARD) -> n x packet (PKT_LEN)
//     -> trailing guard (GUARD) -> idle.
//   Ports:
//     i_pixclk, i_reset_n   pixel clock, synchronous active-low reset
//     i_hSync               horizontal sync, either polarity (edge detected)
//     i_blank               1 = blanking; falling mid-island aborts the island
//     i_enable              0 = suppress all islands
//     i_req[3:0]            requests: [0] ACR, [1] audio, [2] AVI IF, [3] audio IF
//     o_grant[3:0]          one-hot grant, held for the whole packet
//     o_pkt_start           first cycle of each packet
//     o_pkt_offset[4:0]     cycle index within the packet
//     o_first               high during the island's first packet
//     o_preamble, o_guard   preamble / guard-band periods
//     o_island              packet window (TERC4 data enable)
//     o_abort               1-cycle pulse when an island is truncated
//   All outputs are registered.
module hdmi_island_scheduler #(
  parameter int unsigned MAX_PKTS = 2,
  parameter int unsigned PREAMBLE = 8,
  parameter int unsigned GUARD    = 2,
  parameter int unsigned PKT_LEN  = 32
) (
  input  logic       i_pixclk,
  input  logic       i_reset_n,
  input  logic       i_hSync,
  input  logic       i_blank,
  input  logic       i_enable,
  input  logic [3:0] i_req,
  output logic [3:0] o_grant,
  output logic       o_pkt_start,
  output logic [4:0] o_pkt_offset,
  output logic       o_first,
  output logic       o_preamble,
  output logic       o_guard,
  output logic       o_island,
  output logic       o_abort
);

  typedef enum logic [2:0] {IDLE, PRE, LGB, PKT, TGB} state_t;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE - 1);
  localparam logic [7:0] GRD_LAST = 8'(GUARD - 1);
  localparam logic [4:0] OFF_LAST = 5'(PKT_LEN - 1);
  localparam logic [4:0] MAX_P    = 5'(MAX_PKTS);

  state_t     state, stateN;
  logic [7:0] cnt, cntN;
  logic [4:0] pktCnt, pktCntN;
  logic [4:0] offN;
  logic [3:0] grantN, pick;
  logic       firstN, abortN;
  logic       hSyncQ;
  logic       armed, armedN;
  logic       rrPtr, rrN, rrCur;   // 0 = AVI next, 1 = audio IF next
  logic       edgeSeen, arbitrate;

  always_comb begin
    stateN    = state;
    cntN      = '0;
    offN      = '0;
    grantN    = o_grant;
    firstN    = o_first;
    pktCntN   = pktCnt;
    rrN       = rrPtr;
    rrCur     = rrPtr;
    abortN    = 1'b0;
    arbitrate = 1'b0;
    pick      = '0;

    // Only the first hSync edge after blank rises may start an island,
    // whether or not it is acted on.
    edgeSeen = i_blank && armed && (hSyncQ != i_hSync);
    armedN   = armed;
    if (!i_blank)
      armedN = 1'b1;
    else if (edgeSeen)
      armedN = 1'b0;

    case (state)
      IDLE: if (edgeSeen && i_enable && (i_req != '0)) begin
        stateN  = PRE;
        pktCntN = '0;
      end
      PRE: if (cnt == PRE_LAST) stateN = LGB;
           else cntN = cnt + 8'd1;
      LGB: if (cnt == GRD_LAST) arbitrate = 1'b1;
           else cntN = cnt + 8'd1;
      PKT: if (o_pkt_offset == OFF_LAST) begin
        // Round-robin advances only once an infoframe packet completes,
        // so an aborted infoframe is served again next line.
        arbitrate = 1'b1;
        if (o_grant[2])      rrCur = 1'b1;
        else if (o_grant[3]) rrCur = 1'b0;
        rrN = rrCur;
      end else begin
        offN = o_pkt_offset + 5'd1;
      end
      TGB: if (cnt == GRD_LAST) stateN = IDLE;
           else cntN = cnt + 8'd1;
      default: stateN = IDLE;
    endcase

    if (arbitrate) begin
      if (pktCnt < MAX_P) begin
        if (i_req[0])                pick = 4'b0001;
        else if (i_req[1])           pick = 4'b0010;
        else if (i_req[2] && i_req[3]) pick = rrCur ? 4'b1000 : 4'b0100;
        else if (i_req[2])           pick = 4'b0100;
        else if (i_req[3])           pick = 4'b1000;
      end
      if (pick != '0) begin
        stateN  = PKT;
        grantN  = pick;
        offN    = '0;
        firstN  = (pktCnt == '0);
        pktCntN = (pktCnt == 5'd31) ? pktCnt : pktCnt + 5'd1;
      end else begin
        stateN  = TGB;
        grantN  = '0;
        firstN  = 1'b0;
        cntN    = '0;
      end
    end

    if ((state != IDLE) && !i_blank) begin
      stateN = IDLE;
      abortN = 1'b1;
      rrN    = rrPtr;
      grantN = '0;
      firstN = 1'b0;
      offN   = '0;
      cntN   = '0;
    end
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pktCnt       <= '0;
      hSyncQ       <= 1'b0;
      armed        <= 1'b0;
      rrPtr        <= 1'b0;
      o_grant      <= '0;
      o_pkt_start  <= 1'b0;
      o_pkt_offset <= '0;
      o_first      <= 1'b0;
      o_preamble   <= 1'b0;
      o_guard      <= 1'b0;
      o_island     <= 1'b0;
      o_abort      <= 1'b0;
    end else begin
      state        <= stateN;
      cnt          <= cntN;
      pktCnt       <= pktCntN;
      hSyncQ       <= i_hSync;
      armed        <= armedN;
      rrPtr        <= rrN;
      o_grant      <= (stateN == PKT) ? grantN : '0;
      o_pkt_start  <= (stateN == PKT) && (offN == '0);
      o_pkt_offset <= (stateN == PKT) ? offN : '0;
      o_first      <= (stateN == PKT) && firstN;
      o_preamble   <= (stateN == PRE);
      o_guard      <= (stateN == LGB) || (stateN == TGB);
      o_island     <= (stateN == PKT);
      o_abort      <= abortN;
    end
  end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
module tb_hdmi_island_scheduler;

  localparam int PRE_CYC = 8;
  localparam int GRD_CYC = 2;
  localparam int PKT_CYC = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN, hSync, blank, enable;
  logic [3:0] req0, req1;

  logic [3:0] d0Grant, d1Grant;
  logic [4:0] d0Off, d1Off;
  logic       d0Start, d0First, d0Pre, d0Grd, d0Isl, d0Abt;
  logic       d1Start, d1First, d1Pre, d1Grd, d1Isl, d1Abt;

  hdmi_island_scheduler #(.MAX_PKTS(2), .PREAMBLE(8), .GUARD(2), .PKT_LEN(32)) dut0 (
    .i_pixclk(clk), .i_reset_n(resetN), .i_hSync(hSync), .i_blank(blank),
    .i_enable(enable), .i_req(req0), .o_grant(d0Grant), .o_pkt_start(d0Start),
    .o_pkt_offset(d0Off), .o_first(d0First), .o_preamble(d0Pre), .o_guard(d0Grd),
    .o_island(d0Isl), .o_abort(d0Abt));

  hdmi_island_scheduler #(.MAX_PKTS(1), .PREAMBLE(8), .GUARD(2), .PKT_LEN(32)) dut1 (
    .i_pixclk(clk), .i_reset_n(resetN), .i_hSync(hSync), .i_blank(blank),
    .i_enable(enable), .i_req(req1), .o_grant(d1Grant), .o_pkt_start(d1Start),
    .o_pkt_offset(d1Off), .o_first(d1First), .o_preamble(d1Pre), .o_guard(d1Grd),
    .o_island(d1Isl), .o_abort(d1Abt));

  typedef struct packed {
    logic [3:0] grant;
    logic       start;
    logic [4:0] off;
    logic       first;
    logic       pre;
    logic       grd;
    logic       isl;
    logic       abt;
  } outs_t;

  typedef struct {
    outs_t o;
    string nm;
  } exp_t;

  // kind: 0 = full island, 1 = blank falls at offset 'cut', 2 = reset at offset 'cut'
  typedef struct {
    bit         sel;
    logic [3:0] req;
    bit         en;
    logic [3:0] drop;
    int         kind;
    int         cut;
    logic [3:0] g0;
    logic [3:0] g1;
    int         npk;
  } vec_t;

  exp_t q[$];
  vec_t vecs[14];
  int   compared   = 0;
  int   mismatched = 0;
  bit   sel        = 1'b0;

  always @(negedge clk) begin
    outs_t act;
    exp_t  e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (sel) act = {d1Grant, d1Start, d1Off, d1First, d1Pre, d1Grd, d1Isl, d1Abt};
      else     act = {d0Grant, d0Start, d0Off, d0First, d0Pre, d0Grd, d0Isl, d0Abt};
      compared++;
      if (act !== e.o) begin
        mismatched++;
        $display("FAIL %s: got %h want %h (grant/start/off/first/pre/grd/isl/abt)",
                 e.nm, act, e.o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushRec(input string nm, input outs_t o);
    exp_t e;
    e.o  = o;
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic pushIdle(input string nm, input int n);
    for (int i = 0; i < n; i++) pushRec(nm, '0);
  endtask

  task automatic pushIsland(input string nm, input vec_t v);
    outs_t o;
    pushIdle({nm, "_trig"}, 1);
    for (int i = 0; i < PRE_CYC; i++) begin
      o = '0; o.pre = 1'b1; pushRec({nm, "_pre"}, o);
    end
    for (int i = 0; i < GRD_CYC; i++) begin
      o = '0; o.grd = 1'b1; pushRec({nm, "_lgb"}, o);
    end
    if (v.kind != 0) begin
      for (int k = 0; k <= v.cut; k++) begin
        o = '0; o.grant = v.g0; o.start = (k == 0); o.off = 5'(k);
        o.first = 1'b1; o.isl = 1'b1; pushRec({nm, "_pkt"}, o);
      end
      o = '0;
      if (v.kind == 1) o.abt = 1'b1;
      pushRec({nm, (v.kind == 1) ? "_abort" : "_reset"}, o);
      pushIdle({nm, "_after"}, 3);
    end else begin
      for (int p = 0; p < v.npk; p++) begin
        for (int k = 0; k < PKT_CYC; k++) begin
          o = '0; o.grant = (p == 0) ? v.g0 : v.g1; o.start = (k == 0);
          o.off = 5'(k); o.first = (p == 0); o.isl = 1'b1;
          pushRec($sformatf("%s_pkt%0d", nm, p), o);
        end
      end
      for (int i = 0; i < GRD_CYC; i++) begin
        o = '0; o.grd = 1'b1; pushRec({nm, "_tgb"}, o);
      end
      pushIdle({nm, "_end"}, 3);
    end
  endtask

  task automatic drain(input string nm);
    int budget = 400;
    while (q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got %0d pending want 0 pending", nm, q.size());
      q.delete();
    end
  endtask

  task automatic runLine(input int idx);
    vec_t       v;
    string      nm;
    int         budget;
    bit         inRst;
    logic [3:0] r, gG;
    logic [4:0] gO;
    logic       gS, gI, gF;
    v      = vecs[idx];
    nm     = $sformatf("line%0d", idx);
    inRst  = 1'b0;
    blank  = 1'b0;
    enable = v.en;
    sel    = v.sel;
    if (v.sel) begin req1 = v.req; req0 = '0; end
    else       begin req0 = v.req; req1 = '0; end
    repeat (4) tick();
    blank = 1'b1;
    repeat (3) tick();
    hSync = ~hSync;
    if (v.npk == 0) pushIdle({nm, "_none"}, 60);
    else            pushIsland(nm, v);
    budget = 400;
    while (q.size() > 0 && budget > 0) begin
      tick();
      budget--;
      if (inRst) begin resetN = 1'b1; inRst = 1'b0; end
      gG = v.sel ? d1Grant : d0Grant;
      gS = v.sel ? d1Start : d0Start;
      gO = v.sel ? d1Off   : d0Off;
      gI = v.sel ? d1Isl   : d0Isl;
      gF = v.sel ? d1First : d0First;
      r  = v.sel ? req1 : req0;
      if (gS) r = r & ~gG;
      if (gF && gO == 5'd5) r = r & ~v.drop;
      if (v.sel) req1 = r; else req0 = r;
      if (v.kind != 0 && gI && gF && gO == 5'(v.cut)) begin
        if (v.kind == 1) blank = 1'b0;
        else begin resetN = 1'b0; inRst = 1'b1; end
      end
    end
    if (q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got %0d pending want 0 pending", nm, q.size());
      q.delete();
    end
    if (inRst) resetN = 1'b1;
    if (v.kind == 2) begin
      // Request re-raised inside the same blank without a new line: no island.
      if (v.sel) req1 = v.req; else req0 = v.req;
      pushIdle({nm, "_postrst"}, 40);
    end else begin
      // Second hSync edge in the same blank must not start another island.
      hSync = ~hSync;
      pushIdle({nm, "_2nd"}, 40);
    end
    drain(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end want end");
    $fatal(1, "watchdog");
  end

  initial begin
    //          sel   req      en    drop     kind cut g0       g1       npk
    vecs[0]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 0, 0,  4'b0001, 4'b0000, 1};
    vecs[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 0, 0,  4'b0001, 4'b0010, 2};
    vecs[2]  = '{1'b0, 4'b1100, 1'b1, 4'b0000, 0, 0,  4'b0100, 4'b1000, 2};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 0, 0,  4'b0000, 4'b0000, 0};
    vecs[4]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 0, 0,  4'b0000, 4'b0000, 0};
    vecs[5]  = '{1'b0, 4'b0011, 1'b1, 4'b0010, 0, 0,  4'b0001, 4'b0000, 1};
    vecs[6]  = '{1'b0, 4'b0010, 1'b1, 4'b0000, 0, 0,  4'b0010, 4'b0000, 1};
    vecs[7]  = '{1'b0, 4'b1100, 1'b1, 4'b0000, 1, 10, 4'b0100, 4'b0000, 1};
    vecs[8]  = '{1'b0, 4'b1100, 1'b1, 4'b0000, 0, 0,  4'b0100, 4'b1000, 2};
    vecs[9]  = '{1'b1, 4'b1100, 1'b1, 4'b0000, 0, 0,  4'b0100, 4'b0000, 1};
    vecs[10] = '{1'b1, 4'b1100, 1'b1, 4'b0000, 0, 0,  4'b1000, 4'b0000, 1};
    vecs[11] = '{1'b1, 4'b1100, 1'b1, 4'b0000, 0, 0,  4'b0100, 4'b0000, 1};
    vecs[12] = '{1'b0, 4'b0001, 1'b1, 4'b0000, 2, 3,  4'b0001, 4'b0000, 1};
    vecs[13] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 0, 0,  4'b0100, 4'b0000, 1};

    resetN = 1'b0;
    hSync  = 1'b0;
    blank  = 1'b0;
    enable = 1'b0;
    req0   = '0;
    req1   = '0;
    sel    = 1'b0;
    tick();
    pushIdle("reset", 3);
    drain("reset");
    resetN = 1'b1;

    for (int i = 0; i < 14; i++) runLine(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
